mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory port between two vector-processing engines. Each engine-side port carries the same handshake the memory presents (address, read/write strobes, write data, read data, busy, done), so an engine connects unchanged. Grants are round-robin with one transaction in flight at a time. A timeout watchdog and per-port grant counters support debug.

---
 rtl/mem_arbiter_if.sv | 17 +
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-style handshake shared by the engine ports and the memory port.
// master drives address/strobes/write data; slave returns read data/busy/done.
interface mem_arbiter_if #(
  parameter int WA = 32,
  parameter int WD = 32
);
  logic [WA-1:0] A;
  logic          RE;
  logic          WE;
  logic [WD-1:0] D;
  logic [WD-1:0] Q;
  logic          BUSY;
  logic          DONE;

  modport master (output A, RE, WE, D, input Q, BUSY, DONE);
  modport slave  (input A, RE, WE, D, output Q, BUSY, DONE);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port, one transaction
// in flight, with a WAIT-state watchdog and saturating per-port grant counters.
module mem_arbiter #(
  parameter int WA      = 32,
  parameter int WD      = 32,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic           CLK,
  input  logic           RST_X,
  mem_arbiter_if.slave   M0,
  mem_arbiter_if.slave   M1,
  mem_arbiter_if.master  MEM,
  output logic [CW-1:0]  GNT_CNT0,
  output logic [CW-1:0]  GNT_CNT1,
  output logic           ERR
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state_q;
  logic          ptr_q;    // 0: M0 favoured on contention, 1: M1 favoured
  logic          owner_q;  // port owning the in-flight transaction
  logic [TW-1:0] wcnt_q;

  logic [WA-1:0] mem_a_q;
  logic [WD-1:0] mem_d_q;
  logic          mem_re_q;
  logic          mem_we_q;
  logic [WD-1:0] m0_q_q;
  logic [WD-1:0] m1_q_q;
  logic          m0_done_q;
  logic          m1_done_q;
  logic          busy_q;
  logic [CW-1:0] gnt0_q;
  logic [CW-1:0] gnt1_q;
  logic          err_q;

  logic          req0;
  logic          req1;
  logic          grant;
  logic          win;
  logic [WA-1:0] win_a;
  logic [WD-1:0] win_d;
  logic          win_re;
  logic          win_we;
  logic          wait_end;
  logic          timed_out;

  // Winner selection and the selected request's fields; write beats read.
  always_comb begin
    req0      = M0.RE | M0.WE;
    req1      = M1.RE | M1.WE;
    grant     = ~MEM.BUSY & (req0 | req1);
    win       = (req0 & req1) ? ptr_q : req1;
    win_a     = win ? M1.A : M0.A;
    win_d     = win ? M1.D : M0.D;
    win_we    = win ? M1.WE : M0.WE;
    win_re    = win ? (M1.RE & ~M1.WE) : (M0.RE & ~M0.WE);
    timed_out = (wcnt_q == TW'(TIMEOUT - 1));
    wait_end  = MEM.DONE | timed_out;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      wcnt_q    <= '0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      m0_q_q    <= '0;
      m1_q_q    <= '0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      busy_q    <= 1'b0;
      gnt0_q    <= '0;
      gnt1_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= MEM.BUSY;
          if (grant) begin
            mem_a_q  <= win_a;
            mem_d_q  <= win_d;
            mem_we_q <= win_we;
            mem_re_q <= win_re;
            owner_q  <= win;
            ptr_q    <= ~win;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
            if (!win && gnt0_q != '1) gnt0_q <= gnt0_q + 1'b1;
            if (win && gnt1_q != '1)  gnt1_q <= gnt1_q + 1'b1;
          end
        end
        S_ISSUE: begin
          busy_q <= 1'b1;
          if (MEM.BUSY) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            wcnt_q   <= '0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_end) begin
            // A real completion takes priority over a coincident timeout.
            busy_q  <= MEM.BUSY;
            state_q <= S_IDLE;
            if (!owner_q) begin
              m0_done_q <= 1'b1;
              m0_q_q    <= MEM.DONE ? MEM.Q : '0;
            end else begin
              m1_done_q <= 1'b1;
              m1_q_q    <= MEM.DONE ? MEM.Q : '0;
            end
            if (!MEM.DONE) err_q <= 1'b1;
          end else begin
            busy_q <= 1'b1;
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MEM.A    = mem_a_q;
  assign MEM.D    = mem_d_q;
  assign MEM.RE   = mem_re_q;
  assign MEM.WE   = mem_we_q;
  assign M0.Q     = m0_q_q;
  assign M1.Q     = m1_q_q;
  assign M0.DONE  = m0_done_q;
  assign M1.DONE  = m1_done_q;
  assign M0.BUSY  = busy_q;
  assign M1.BUSY  = busy_q;
  assign GNT_CNT0 = gnt0_q;
  assign GNT_CNT1 = gnt1_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both engines and the memory.
module tb_mem_arbiter;

  localparam int WA = 32;
  localparam int WD = 32;
  localparam int CW = 16;

  logic          CLK;
  logic          RST_X;
  logic [CW-1:0] GNT_CNT0;
  logic [CW-1:0] GNT_CNT1;
  logic          ERR;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  mem_arbiter_if #(.WA(WA), .WD(WD)) if_m0 ();
  mem_arbiter_if #(.WA(WA), .WD(WD)) if_m1 ();
  mem_arbiter_if #(.WA(WA), .WD(WD)) if_mem ();

  mem_arbiter #(.WA(WA), .WD(WD), .TIMEOUT(8), .CW(CW)) dut (
    .CLK      (CLK),
    .RST_X    (RST_X),
    .M0       (if_m0),
    .M1       (if_m1),
    .MEM      (if_mem),
    .GNT_CNT0 (GNT_CNT0),
    .GNT_CNT1 (GNT_CNT1),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST_X = 1'b0;
    if_m0.A = '0; if_m0.RE = 1'b0; if_m0.WE = 1'b0; if_m0.D = '0;
    if_m1.A = '0; if_m1.RE = 1'b0; if_m1.WE = 1'b0; if_m1.D = '0;
    if_mem.Q = '0; if_mem.BUSY = 1'b0; if_mem.DONE = 1'b0;
    tick();
    tick();
    RST_X = 1'b1;
  endtask

  // Memory responder: waits for a strobe, raises BUSY for busy_cycles edges,
  // then returns DONE with q. Returns just after the DONE edge.
  task automatic serve(input logic [WD-1:0] q, input int unsigned busy_cycles,
                       output logic [WA-1:0] a_seen, output logic re_seen,
                       output logic we_seen, output logic [WD-1:0] d_seen,
                       output bit ok);
    ok = 1'b0;
    a_seen = '0; re_seen = 1'b0; we_seen = 1'b0; d_seen = '0;
    for (int i = 0; i < 50; i++) begin
      if (if_mem.RE | if_mem.WE) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      a_seen  = if_mem.A;
      re_seen = if_mem.RE;
      we_seen = if_mem.WE;
      d_seen  = if_mem.D;
      if_mem.BUSY = 1'b1;
      for (int unsigned i = 0; i < busy_cycles; i++) tick();
      if_mem.BUSY = 1'b0;
      if_mem.DONE = 1'b1;
      if_mem.Q    = q;
      tick();
      if_mem.DONE = 1'b0;
      if_mem.Q    = '0;
    end
  endtask

  task automatic test_reset;
    logic any;
    RST_X = 1'b0;
    do_reset();
    any = |{if_mem.A, if_mem.RE, if_mem.WE, if_mem.D, if_m0.Q, if_m0.BUSY, if_m0.DONE,
            if_m1.Q, if_m1.BUSY, if_m1.DONE, GNT_CNT0, GNT_CNT1, ERR};
    total_cnt++;
    if (any !== 1'b0) $display("FAIL reset_outputs: any-set=%b required 0", any);
    else pass_cnt++;
  endtask

  task automatic test_single_read;
    do_reset();
    if_m0.RE = 1'b1; if_m0.A = 32'h40;
    tick();
    total_cnt++;
    if ({if_mem.RE, if_mem.WE, if_mem.A, if_m0.BUSY, if_m1.BUSY} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b1})
      $display("FAIL read_grant: re=%b we=%b a=%h b0=%b b1=%b required 1 0 00000040 1 1",
               if_mem.RE, if_mem.WE, if_mem.A, if_m0.BUSY, if_m1.BUSY);
    else pass_cnt++;
    if_m0.RE = 1'b0;
    tick();
    total_cnt++;
    if (if_mem.RE !== 1'b1) $display("FAIL read_hold: re=%b required 1", if_mem.RE);
    else pass_cnt++;
    if_mem.BUSY = 1'b1;
    tick();
    total_cnt++;
    if (if_mem.RE !== 1'b0) $display("FAIL read_drop: re=%b required 0", if_mem.RE);
    else pass_cnt++;
    tick();
    tick();
    if_mem.BUSY = 1'b0; if_mem.DONE = 1'b1; if_mem.Q = 32'h1234;
    tick();
    total_cnt++;
    if ({if_m0.Q, if_m0.DONE, if_m1.DONE, if_m1.Q, if_m0.BUSY, GNT_CNT0} !==
        {32'h1234, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1})
      $display("FAIL read_done: q0=%h d0=%b d1=%b q1=%h b0=%b g0=%0d required 00001234 1 0 00000000 0 1",
               if_m0.Q, if_m0.DONE, if_m1.DONE, if_m1.Q, if_m0.BUSY, GNT_CNT0);
    else pass_cnt++;
    if_mem.DONE = 1'b0; if_mem.Q = '0;
    tick();
    total_cnt++;
    if ({if_m0.DONE, if_m0.Q} !== {1'b0, 32'h1234})
      $display("FAIL read_pulse: d0=%b q0=%h required 0 00001234", if_m0.DONE, if_m0.Q);
    else pass_cnt++;
  endtask

  task automatic test_contention;
    logic [WA-1:0] a; logic re, we; logic [WD-1:0] d; bit ok;
    logic [WA-1:0] exp_a; logic [WD-1:0] exp_q;
    do_reset();
    if_m0.RE = 1'b1; if_m0.A = 32'h100;
    if_m1.RE = 1'b1; if_m1.A = 32'h200;
    for (int k = 0; k < 6; k++) begin
      exp_q = 32'hC000 + 32'(k);
      exp_a = (k % 2 == 1) ? 32'h200 : 32'h100;
      serve(exp_q, 1, a, re, we, d, ok);
      if (k == 5) begin
        if_m0.RE = 1'b0;
        if_m1.RE = 1'b0;
      end
      total_cnt++;
      if ({ok, a} !== {1'b1, exp_a})
        $display("FAIL rr_order[%0d]: ok=%b a=%h required 1 %h", k, ok, a, exp_a);
      else pass_cnt++;
      total_cnt++;
      if ((k % 2 == 1) ? ({if_m1.DONE, if_m0.DONE, if_m1.Q} !== {1'b1, 1'b0, exp_q})
                       : ({if_m1.DONE, if_m0.DONE, if_m0.Q} !== {1'b0, 1'b1, exp_q}))
        $display("FAIL rr_done[%0d]: d1=%b d0=%b q1=%h q0=%h required owner=%0d q=%h",
                 k, if_m1.DONE, if_m0.DONE, if_m1.Q, if_m0.Q, k % 2, exp_q);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({GNT_CNT0, GNT_CNT1, if_mem.RE} !== {16'd3, 16'd3, 1'b0})
      $display("FAIL rr_counts: g0=%0d g1=%0d re=%b required 3 3 0", GNT_CNT0, GNT_CNT1, if_mem.RE);
    else pass_cnt++;
  endtask

  task automatic test_write_priority;
    logic [WA-1:0] a; logic re, we; logic [WD-1:0] d; bit ok;
    do_reset();
    if_m1.RE = 1'b1; if_m1.WE = 1'b1; if_m1.D = 32'hAA; if_m1.A = 32'h300;
    serve(32'h0, 2, a, re, we, d, ok);
    if_m1.RE = 1'b0; if_m1.WE = 1'b0;
    total_cnt++;
    if ({ok, we, re, d, a} !== {1'b1, 1'b1, 1'b0, 32'hAA, 32'h300})
      $display("FAIL write_prio: ok=%b we=%b re=%b d=%h a=%h required 1 1 0 000000aa 00000300",
               ok, we, re, d, a);
    else pass_cnt++;
    total_cnt++;
    if ({if_m1.DONE, GNT_CNT1, GNT_CNT0} !== {1'b1, 16'd1, 16'd0})
      $display("FAIL write_done: d1=%b g1=%0d g0=%0d required 1 1 0", if_m1.DONE, GNT_CNT1, GNT_CNT0);
    else pass_cnt++;
  endtask

  task automatic test_mem_busy_idle;
    logic [WA-1:0] a; logic re, we; logic [WD-1:0] d; bit ok;
    do_reset();
    if_mem.BUSY = 1'b1;
    tick();
    if_m0.RE = 1'b1; if_m0.A = 32'h50;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({if_mem.RE, if_m0.BUSY, if_m1.BUSY} !== 3'b011)
        $display("FAIL busy_block[%0d]: re=%b b0=%b b1=%b required 0 1 1", i, if_mem.RE, if_m0.BUSY, if_m1.BUSY);
      else pass_cnt++;
    end
    if_mem.BUSY = 1'b0;
    if_m0.RE = 1'b0;
    tick();
    total_cnt++;
    if ({if_mem.RE, if_m0.BUSY} !== 2'b00)
      $display("FAIL busy_track: re=%b b0=%b required 0 0", if_mem.RE, if_m0.BUSY);
    else pass_cnt++;
    if_m0.RE = 1'b1;
    tick();
    total_cnt++;
    if ({if_mem.RE, if_mem.A, if_m0.BUSY} !== {1'b1, 32'h50, 1'b1})
      $display("FAIL busy_release: re=%b a=%h b0=%b required 1 00000050 1", if_mem.RE, if_mem.A, if_m0.BUSY);
    else pass_cnt++;
    serve(32'h9, 1, a, re, we, d, ok);
    if_m0.RE = 1'b0;
    total_cnt++;
    if ({ok, if_m0.DONE, if_m0.Q} !== {1'b1, 1'b1, 32'h9})
      $display("FAIL busy_done: ok=%b d0=%b q0=%h required 1 1 00000009", ok, if_m0.DONE, if_m0.Q);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    logic [WA-1:0] a; logic re, we; logic [WD-1:0] d; bit ok;
    int n;
    do_reset();
    if_m0.RE = 1'b1; if_m0.A = 32'h60;
    serve(32'h5555, 1, a, re, we, d, ok);
    if_m0.RE = 1'b0;
    total_cnt++;
    if ({ok, if_m0.Q, ERR} !== {1'b1, 32'h5555, 1'b0})
      $display("FAIL to_pre: ok=%b q0=%h err=%b required 1 00005555 0", ok, if_m0.Q, ERR);
    else pass_cnt++;
    tick();
    if_m0.RE = 1'b1;
    tick();
    if_m0.RE = 1'b0;
    if_mem.BUSY = 1'b1;
    tick();
    if_mem.BUSY = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (if_m0.DONE === 1'b1) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if ({32'(n), if_m0.Q, ERR, if_m1.DONE} !== {32'd8, 32'h0, 1'b1, 1'b0})
      $display("FAIL timeout: cycles=%0d q0=%h err=%b d1=%b required 8 00000000 1 0", n, if_m0.Q, ERR, if_m1.DONE);
    else pass_cnt++;
    tick();
    if_m0.RE = 1'b1;
    serve(32'h7777, 1, a, re, we, d, ok);
    if_m0.RE = 1'b0;
    total_cnt++;
    if ({ok, if_m0.Q, ERR, GNT_CNT0} !== {1'b1, 32'h7777, 1'b1, 16'd3})
      $display("FAIL err_sticky: ok=%b q0=%h err=%b g0=%0d required 1 00007777 1 3", ok, if_m0.Q, ERR, GNT_CNT0);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait;
    logic [WA-1:0] a; logic re, we; logic [WD-1:0] d; bit ok;
    logic any;
    tick();
    if_m0.RE = 1'b1; if_m0.A = 32'h70;
    tick();
    if_m0.RE = 1'b0;
    if_mem.BUSY = 1'b1;
    tick();
    #2;
    RST_X = 1'b0;
    #1;
    any = |{if_mem.A, if_mem.RE, if_mem.WE, if_mem.D, if_m0.Q, if_m0.BUSY, if_m0.DONE,
            if_m1.Q, if_m1.BUSY, if_m1.DONE, GNT_CNT0, GNT_CNT1, ERR};
    total_cnt++;
    if (any !== 1'b0) $display("FAIL async_reset: any-set=%b required 0", any);
    else pass_cnt++;
    if_mem.BUSY = 1'b0;
    if_mem.DONE = 1'b1; if_mem.Q = 32'hDEAD;
    tick();
    total_cnt++;
    if ({if_m0.DONE, if_m1.DONE, if_m0.Q} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL reset_no_done: d0=%b d1=%b q0=%h required 0 0 00000000", if_m0.DONE, if_m1.DONE, if_m0.Q);
    else pass_cnt++;
    if_mem.DONE = 1'b0; if_mem.Q = '0;
    #2;
    RST_X = 1'b1;
    if_m0.RE = 1'b1; if_m0.A = 32'h100;
    if_m1.RE = 1'b1; if_m1.A = 32'h200;
    serve(32'h1, 1, a, re, we, d, ok);
    if_m0.RE = 1'b0; if_m1.RE = 1'b0;
    total_cnt++;
    if ({ok, a, if_m0.DONE} !== {1'b1, 32'h100, 1'b1})
      $display("FAIL post_reset_rr: ok=%b a=%h d0=%b required 1 00000100 1", ok, a, if_m0.DONE);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RST_X     = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_priority();
    test_mem_busy_idle();
    test_timeout();
    test_reset_in_wait();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
